log: RTL and testbench

//  Calculator execute-unit that computes o_log = log_a(b), where a is the base and b the argument.

---
 rtl/log.sv | 201 ++++++++++++++++++++
 tb/tb_log.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/log.sv
// -----------------------------------------------------------------------------
// log : calculator execute unit computing o_log = log_a(b) in signed Q16.8.
//
// Ports
//   CLK     in   1  clock, rising edge
//   RST     in   1  synchronous active-high reset
//   a       in   N  signed base
//   b       in   N  signed argument
//   state   in   3  controller state; the unit runs while state == ST_EXECB
//   opcode  in   4  operation select; the unit runs while opcode == OP_LOG
//   o_log   out  M  signed Q.8 result, 0 on error
//   done    out  1  result/error valid, held while the request stays up
//   error   out  1  invalid operands (a <= 1 or b <= 0), valid with done
//
// Flow: S_IDLE samples the operands, S_LOG builds log2(a) and log2(b) as
// 4.16 unsigned values by repeated squaring, and S_DIV forms
// (log2(b) << 8) / log2(a) by restoring division with round-to-nearest.
// -----------------------------------------------------------------------------
module log #(
    parameter int          N        = 16,
    parameter int          M        = 24,
    parameter int          W        = 24,
    parameter logic [2:0]  ST_EXECB = 3'd2,
    parameter logic [3:0]  OP_LOG   = 4'd8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   state,
    input  logic [3:0]   opcode,
    output logic [M-1:0] o_log,
    output logic         done,
    output logic         error
);

    localparam int FB = 16;        // fractional log2 bits
    localparam int LW = 4 + FB;    // log2 width: 4 integer + 16 fraction

    typedef enum logic [1:0] {S_IDLE, S_LOG, S_DIV, S_DONE} fsm_t;

    fsm_t          fsm_q,  fsm_d;
    logic [4:0]    cnt_q,  cnt_d;
    logic [W-1:0]  ma_q,   ma_d;     // mantissas, Q1.(W-1) in [1,2)
    logic [W-1:0]  mb_q,   mb_d;
    logic [LW-1:0] la_q,   la_d;
    logic [LW-1:0] lb_q,   lb_d;
    logic [LW-1:0] rem_q,  rem_d;
    logic [M-1:0]  dvd_q,  dvd_d;    // low dividend bits still to shift in
    logic [M-1:0]  quo_q,  quo_d;
    logic [M-1:0]  o_log_q, o_log_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic            req;
    logic            bad_op;
    logic [3:0]      ka, kb;
    logic [2*W-1:0]  pa, pb;
    logic            bit_a, bit_b;
    logic [LW:0]     r2;
    logic [LW-1:0]   rem_n;
    logic            qbit, rnd;
    logic [M-1:0]    quo_n;

    function automatic logic [3:0] msb_idx(input logic [N-1:0] x);
        msb_idx = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) msb_idx = 4'(i);
    endfunction

    // Shift the leading one up to bit W-1 so the mantissa sits in [1,2).
    function automatic logic [W-1:0] norm(input logic [N-1:0] x, input logic [3:0] k);
        norm = W'(x) << (W - 1 - int'(k));
    endfunction

    assign req    = (state == ST_EXECB) && (opcode == OP_LOG);
    assign bad_op = a[N-1] || (a[N-1:1] == '0) || b[N-1] || (b == '0);
    assign ka     = msb_idx(a);
    assign kb     = msb_idx(b);

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        la_d    = la_q;
        lb_d    = lb_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        o_log_d = o_log_q;
        done_d  = done_q;
        error_d = error_q;

        pa    = {{W{1'b0}}, ma_q} * {{W{1'b0}}, ma_q};
        pb    = {{W{1'b0}}, mb_q} * {{W{1'b0}}, mb_q};
        bit_a = pa[2*W-1];
        bit_b = pb[2*W-1];

        r2    = {rem_q, dvd_q[M-1]};
        qbit  = (r2 >= {1'b0, la_q});
        rem_n = qbit ? LW'(r2 - {1'b0, la_q}) : r2[LW-1:0];
        quo_n = {quo_q[M-2:0], qbit};
        rnd   = ({rem_n, 1'b0} >= {1'b0, la_q});

        case (fsm_q)
            S_IDLE: begin
                if (req) begin
                    if (bad_op) begin
                        o_log_d = '0;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        fsm_d   = S_DONE;
                    end else begin
                        la_d  = {ka, {FB{1'b0}}};
                        lb_d  = {kb, {FB{1'b0}}};
                        ma_d  = norm(a, ka);
                        mb_d  = norm(b, kb);
                        cnt_d = '0;
                        fsm_d = S_LOG;
                    end
                end
            end
            S_LOG: begin
                // m*m is Q2.(2W-2); a set top bit means m*m >= 2, halve it.
                ma_d  = bit_a ? pa[2*W-1:W] : pa[2*W-2:W-1];
                mb_d  = bit_b ? pb[2*W-1:W] : pb[2*W-2:W-1];
                la_d  = {la_q[LW-1:FB], la_q[FB-2:0], bit_a};
                lb_d  = {lb_q[LW-1:FB], lb_q[FB-2:0], bit_b};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(FB - 1)) begin
                    // Dividend is lb<<8 (28 bits). Its top 4 bits are below
                    // la (>= 1.0), so they seed the remainder and M steps
                    // over the remaining bits give the full quotient.
                    rem_d = {{FB{1'b0}}, lb_d[LW-1:FB]};
                    dvd_d = {lb_d[FB-1:0], 8'b0};
                    quo_d = '0;
                    cnt_d = '0;
                    fsm_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_n;
                quo_d = quo_n;
                dvd_d = {dvd_q[M-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(M - 1)) begin
                    o_log_d = quo_n + M'(rnd);
                    done_d  = 1'b1;
                    error_d = 1'b0;
                    fsm_d   = S_DONE;
                end
            end
            S_DONE: ;
            default: fsm_d = S_IDLE;
        endcase

        // Dropping the request aborts everything; the last result stays visible.
        if (!req) begin
            fsm_d   = S_IDLE;
            done_d  = 1'b0;
            error_d = 1'b0;
            o_log_d = o_log_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            la_q    <= '0;
            lb_q    <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            o_log_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            o_log_q <= o_log_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_log = o_log_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_log.sv
// -----------------------------------------------------------------------------
// tb_log : directed bench for log. Expected results are queued when a request
// is launched and popped when done rises.
// -----------------------------------------------------------------------------
module tb_log;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXECB = 3'd2;
    localparam logic [3:0] OP_LOG   = 4'd8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] a, b;
    logic [2:0]  state;
    logic [3:0]  opcode;
    logic [23:0] o_log;
    logic        done, error;

    typedef struct {
        string tag;
        int    val;
        bit    err;
        int    tol;
    } exp_t;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;
    int   lat;

    log #(.N(16), .M(24), .W(24), .ST_EXECB(ST_EXECB), .OP_LOG(OP_LOG)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .a      (a),
        .b      (b),
        .state  (state),
        .opcode (opcode),
        .o_log  (o_log),
        .done   (done),
        .error  (error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        total++;
        assert ((obs >= expv - tol) && (obs <= expv + tol)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, expv, tol);
        end
    endtask

    // Launch a request, wait for done, compare against the queued expectation.
    // The request is left asserted; the caller decides when to drop it.
    task automatic run(input string tag, input int av, input int bv,
                       input int ev, input bit ee, input int tol);
        exp_t e;
        bit   got;
        q_exp.push_back('{tag, ev, ee, tol});
        a      = 16'(av);
        b      = 16'(bv);
        state  = ST_EXECB;
        opcode = OP_LOG;
        got    = 1'b0;
        lat    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            lat++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        e = q_exp.pop_front();
        chk({e.tag, " done"}, 32'(got), 32'd1);
        if (got) begin
            chk({e.tag, " error"}, 32'(error), 32'(e.err));
            chk_tol({e.tag, " o_log"}, int'($signed(o_log)), e.val, e.tol);
        end
    endtask

    task automatic release_req(input string tag);
        state = ST_IDLE;
        @(negedge CLK);
        chk({tag, " done clear"}, 32'(done), 32'd0);
    endtask

    initial begin
        int stray;
        RST    = 1'b1;
        a      = '0;
        b      = '0;
        state  = ST_IDLE;
        opcode = OP_LOG;
        repeat (2) @(negedge CLK);
        chk("reset done",  32'(done),  32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset o_log", 32'(o_log), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Valid operand sets
        run("log12(3)",     12, 3,     113,  1'b0, 0); release_req("log12(3)");
        chk_tol("latency bound", lat, 45, 5);
        run("log4(16)",     4,  16,    512,  1'b0, 0); release_req("log4(16)");
        run("log3(27)",     3,  27,    768,  1'b0, 0); release_req("log3(27)");
        run("log3(36)",     3,  36,    835,  1'b0, 1); release_req("log3(36)");
        run("log10(1000)",  10, 1000,  768,  1'b0, 0); release_req("log10(1000)");
        run("log7(343)",    7,  343,   768,  1'b0, 0); release_req("log7(343)");
        run("log2(32767)",  2,  32767, 3840, 1'b0, 1); release_req("log2(32767)");
        run("log5(2)",      5,  2,     110,  1'b0, 1); release_req("log5(2)");
        run("log9(1)",      9,  1,     0,    1'b0, 0); release_req("log9(1)");
        run("log2(4096)",   2,  4096,  3072, 1'b0, 0); release_req("log2(4096)");

        // Invalid operands
        run("err a1b1",   1,  1,  0, 1'b1, 0); release_req("err a1b1");
        run("err a0",     0,  8,  0, 1'b1, 0); release_req("err a0");
        run("err a-5",    -5, 8,  0, 1'b1, 0); release_req("err a-5");
        run("err b0",     3,  0,  0, 1'b1, 0); release_req("err b0");
        run("err b-3",    3,  -3, 0, 1'b1, 0); release_req("err b-3");
        chk("err latency", 32'(lat), 32'd1);

        // Set a known nonzero result, then abort a run mid-way.
        run("pre abort",  10, 1000, 768, 1'b0, 0); release_req("pre abort");
        a = 16'd3; b = 16'd27; state = ST_EXECB; opcode = OP_LOG;
        repeat (10) @(negedge CLK);
        state = ST_IDLE;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done !== 1'b0) stray++;
        end
        chk("abort done stays 0", 32'(stray), 32'd0);
        chk("abort keeps o_log",  32'(o_log), 32'd768);
        run("log2(8)",    2,  8,    768, 1'b0, 0); release_req("log2(8)");
        chk_tol("rerun full latency", lat, 45, 5);

        // Reset mid-computation
        a = 16'd3; b = 16'd27; state = ST_EXECB; opcode = OP_LOG;
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst done",  32'(done),  32'd0);
        chk("midrst error", 32'(error), 32'd0);
        chk("midrst o_log", 32'(o_log), 32'd0);
        RST   = 1'b0;
        state = ST_IDLE;
        @(negedge CLK);

        // Hold request after done and change the operands
        run("hold log4(16)", 4, 16, 512, 1'b0, 0);
        a = 16'd3; b = 16'd36;
        repeat (8) @(negedge CLK);
        chk("hold done",  32'(done),  32'd1);
        chk("hold o_log", 32'(o_log), 32'd512);
        release_req("hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
